mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between the EX/MEM and MEM/WB registers.
//  - Non-memory ops: ALU result passes straight through to write-back.
//  - Loads/stores: executed as a sequence of byte accesses on the shared 8-bit RAM port.
//  - Pipeline is held via a stall request until the whole access is complete.
// PARAMETERS
//  ADDR_W   32   width of mem_a_o; low ADDR_W bits of the byte address are driven
// PORTS
//  clk                 in   1         stage clock
//  rst                 in   1         async reset, active-high
//  aluop_EXMEM_i       in   AluOpBus  op code; LB/LH/LW/LBU/LHU/SB/SH/SW select memory path
//  wreg_EXMEM_i        in   1         rd write enable
//  waddr_EXMEM_i       in   5         rd index
//  alurslt_EXMEM_i     in   32        ALU result; effective byte address for ld/st
//  SdataBoffset_EXMEM_i in  32        store data (rs2) for SB/SH/SW
//  mem_gnt_i           in   1         RAM port granted by the IF/MEM arbiter
//  mem_din_i           in   8         RAM read byte; valid 1 cycle after its address
//  mem_req_o           out  1         RAM port request
//  mem_a_o             out  ADDR_W    RAM byte address
//  mem_dout_o          out  8         RAM write byte
//  mem_wr_o            out  1         RAM write strobe (1 = write this cycle)
//  stallreq_MEM_o      out  1         hold PC, IF/ID, ID/EX and EX/MEM
//  wreg_MEMWB_o        out  1         to MEM/WB and ID forwarding
//  waddr_MEMWB_o       out  5         to MEM/WB and ID forwarding
//  wdata_MEMWB_o       out  32        to MEM/WB and ID forwarding
// BEHAVIOUR
//  Reset:
//  - Async reset forces state IDLE, cnt=0 and all outputs 0; an access in flight is abandoned.
//  - No further RAM write occurs after rst asserts.
//  Byte count and ordering:
//  - Access size N = 1 (B/BU), 2 (H/HU), 4 (W). Little-endian: byte i at addr+i.
//  - No alignment check; addr+i wraps modulo 2^ADDR_W.
//  FSM states: IDLE, REQ, XFER, WAIT, DONE.
//  - IDLE, non-mem op: wreg/waddr/wdata = inputs (wdata = alurslt); stall=0; req=0.
//  - IDLE, mem op: stall=1, req=1, wreg_o=0. Go to XFER if gnt, else to REQ.
//  - REQ: req=1, stall=1. Move to XFER when gnt=1.
//  - XFER: req=1, stall=1.
//    - Drive mem_a_o = addr+cnt.
//    - Store: mem_wr_o=1, mem_dout_o = store_data[8*cnt+:8].
//    - Load: mem_wr_o=0; mem_din_i is captured as byte cnt-1 when cnt>0.
//    - cnt increments each cycle. At cnt==N-1: load goes to WAIT, store goes to DONE.
//  - WAIT (load only): capture byte N-1; req=1, stall=1; go to DONE.
//  - DONE: req=0, stall=0; wreg/waddr = inputs. Go to IDLE.
//    - Load: wdata = assembled value, sign-extended for LB/LH, zero-extended for LBU/LHU/LW.
//    - Store: wdata = 0.
//  Grant rules:
//  - mem_gnt_i is sampled only in IDLE and REQ.
//  - The arbiter must hold the grant while req=1. Gnt dropping in XFER/WAIT is ignored.
//  - Holding req continuously through XFER and WAIT is what keeps IF off the RAM port.
//  Latency with gnt tied 1 (cycles incl. DONE): LB/LBU 4, LH/LHU 5, LW 7, SB 3, SH 4, SW 6.
//  Back-to-back ops:
//  - Stall is low in DONE, so the pipeline advances at that edge.
//  - The next cycle IDLE sees the new op. Two identical consecutive stores therefore both execute.
//  Hold requirement: EX/MEM inputs must stay stable while stallreq_MEM_o=1.
//  Registered vs combinational:
//  - Registered: cnt, state, byte buffer.
//  - Combinational from state/cnt/inputs: mem_*_o, stall, MEMWB outputs.
// STRUCTURE
//  - macro.vh (shared): ALU_*_OP codes, AluOpBus, Enable/Disable, ZeroWord, NopRegAddr.
//  - macro.vh additions: MEM_IDLE/REQ/XFER/WAIT/DONE encodings (3 bits), MemStateBus.
//  - Sub-module load_extend (combinational): 32-bit byte buffer + aluop -> sign/zero-extended wdata.
//  - Top level: FSM, 2-bit cnt, byte buffer, output mux.
// TESTING
//  - ADD passthrough: aluop=ADD, wreg=1, waddr=5, alurslt=0x1234 -> same cycle wreg=1, waddr=5,
//    wdata=0x1234, stall=0, req=0.
//  - LW, gnt=1, RAM[0x100..0x103]=78 56 34 12
//    -> mem_a_o 0x100..0x103 on cycles 1-4.
//    -> stall on cycles 0-5.
//    -> cycle 6: wdata=0x12345678, wreg=1.
//  - LB/LBU at 0x200 holding 0x80 -> LB wdata=0xFFFFFF80, LBU wdata=0x00000080.
//    LH at 0x202 with 0x8001 -> wdata=0xFFFF8001.
//  - SH addr=0x300, data=0xAABBCCDD, gnt delayed 3 cycles
//    -> req high from cycle 0; no write before gnt.
//    -> writes 0xDD@0x300 then 0xCC@0x301.
//    -> exactly 2 strobes; 0x302 untouched.
//  - Two consecutive SB to 0x10 (data 0x11, then 0x22) -> two separate write strobes; final RAM[0x10]=0x22.
//  - rst pulse during XFER of SW after byte 1 written
//    -> all outputs 0 immediately; no further mem_wr_o.
//    -> after release, a new ADD passes through in IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared op codes, state encoding and access-size helpers
// for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int ALUOP_W = 8;

  typedef logic [ALUOP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_NOP_OP = 8'h00;
  localparam alu_op_t ALU_ADD_OP = 8'h01;
  localparam alu_op_t ALU_SUB_OP = 8'h02;
  localparam alu_op_t ALU_AND_OP = 8'h03;
  localparam alu_op_t ALU_OR_OP  = 8'h04;
  localparam alu_op_t ALU_LB_OP  = 8'h10;
  localparam alu_op_t ALU_LH_OP  = 8'h11;
  localparam alu_op_t ALU_LW_OP  = 8'h12;
  localparam alu_op_t ALU_LBU_OP = 8'h13;
  localparam alu_op_t ALU_LHU_OP = 8'h14;
  localparam alu_op_t ALU_SB_OP  = 8'h18;
  localparam alu_op_t ALU_SH_OP  = 8'h19;
  localparam alu_op_t ALU_SW_OP  = 8'h1a;

  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

  typedef enum logic [2:0] {
    MEM_IDLE = 3'd0,
    MEM_REQ  = 3'd1,
    MEM_XFER = 3'd2,
    MEM_WAIT = 3'd3,
    MEM_DONE = 3'd4
  } mem_state_t;

  function automatic logic is_load(alu_op_t op);
    return op inside {ALU_LB_OP, ALU_LH_OP, ALU_LW_OP,
                      ALU_LBU_OP, ALU_LHU_OP};
  endfunction

  function automatic logic is_store(alu_op_t op);
    return op inside {ALU_SB_OP, ALU_SH_OP, ALU_SW_OP};
  endfunction

  // Index of the final byte of the access (size - 1).
  function automatic logic [1:0] last_idx(alu_op_t op);
    logic [1:0] r;
    r = 2'd0;
    if (op inside {ALU_LW_OP, ALU_SW_OP})
      r = 2'd3;
    else if (op inside {ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP})
      r = 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of the assembled load bytes
// according to the load flavour.
import mem_stage_pkg::*;

module mem_stage_load_extend (
  input  alu_op_t     aluop,
  input  logic [31:0] bytes,
  output logic [31:0] wdata
);

  always_comb begin
    wdata = bytes;
    unique case (1'b1)
      aluop == ALU_LB_OP:  wdata = {{24{bytes[7]}}, bytes[7:0]};
      aluop == ALU_LBU_OP: wdata = {24'd0, bytes[7:0]};
      aluop == ALU_LH_OP:  wdata = {{16{bytes[15]}}, bytes[15:0]};
      aluop == ALU_LHU_OP: wdata = {16'd0, bytes[15:0]};
      default:             wdata = bytes;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU passthrough, or byte-serial load/store
// over the shared 8-bit RAM port while stalling the pipeline.
import mem_stage_pkg::*;

module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  alu_op_t           aluop_EXMEM_i,
  input  logic              wreg_EXMEM_i,
  input  logic [4:0]        waddr_EXMEM_i,
  input  logic [31:0]       alurslt_EXMEM_i,
  input  logic [31:0]       SdataBoffset_EXMEM_i,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_din_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              stallreq_MEM_o,
  output logic              wreg_MEMWB_o,
  output logic [4:0]        waddr_MEMWB_o,
  output logic [31:0]       wdata_MEMWB_o
);

  mem_state_t  state;
  logic [1:0]  cnt;
  logic [31:0] bytes_q;
  logic [31:0] ext;
  logic [31:0] addr;
  logic        ld;
  logic        st;
  logic [1:0]  last;

  assign ld   = is_load(aluop_EXMEM_i);
  assign st   = is_store(aluop_EXMEM_i);
  assign last = last_idx(aluop_EXMEM_i);
  assign addr = alurslt_EXMEM_i + {30'd0, cnt};

  mem_stage_load_extend u_ext (
    .aluop (aluop_EXMEM_i),
    .bytes (bytes_q),
    .wdata (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MEM_IDLE;
      cnt     <= 2'd0;
      bytes_q <= ZERO_WORD;
    end else begin
      unique case (state)
        MEM_IDLE: begin
          cnt <= 2'd0;
          if (ld || st)
            state <= mem_gnt_i ? MEM_XFER : MEM_REQ;
        end
        MEM_REQ: begin
          if (mem_gnt_i)
            state <= MEM_XFER;
        end
        MEM_XFER: begin
          cnt <= cnt + 2'd1;
          // read data lags its address by one cycle
          if (ld && cnt != 2'd0)
            bytes_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_din_i;
          if (cnt == last)
            state <= ld ? MEM_WAIT : MEM_DONE;
        end
        MEM_WAIT: begin
          bytes_q[{last, 3'b000} +: 8] <= mem_din_i;
          state <= MEM_DONE;
        end
        MEM_DONE: begin
          cnt   <= 2'd0;
          state <= MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_a_o        = '0;
    mem_dout_o     = 8'd0;
    mem_wr_o       = 1'b0;
    stallreq_MEM_o = 1'b0;
    wreg_MEMWB_o   = 1'b0;
    waddr_MEMWB_o  = NOP_REG_ADDR;
    wdata_MEMWB_o  = ZERO_WORD;
    if (!rst) begin
      unique case (state)
        MEM_IDLE: begin
          if (ld || st) begin
            mem_req_o      = 1'b1;
            stallreq_MEM_o = 1'b1;
          end else begin
            wreg_MEMWB_o  = wreg_EXMEM_i;
            waddr_MEMWB_o = waddr_EXMEM_i;
            wdata_MEMWB_o = alurslt_EXMEM_i;
          end
        end
        MEM_XFER: begin
          mem_req_o      = 1'b1;
          stallreq_MEM_o = 1'b1;
          mem_a_o        = addr[ADDR_W-1:0];
          if (st) begin
            mem_wr_o   = 1'b1;
            mem_dout_o = SdataBoffset_EXMEM_i[{cnt, 3'b000} +: 8];
          end
        end
        MEM_REQ, MEM_WAIT: begin
          mem_req_o      = 1'b1;
          stallreq_MEM_o = 1'b1;
        end
        MEM_DONE: begin
          wreg_MEMWB_o  = wreg_EXMEM_i;
          waddr_MEMWB_o = waddr_EXMEM_i;
          wdata_MEMWB_o = ld ? ext : ZERO_WORD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset abort
// sequence and random ops against a byte-array memory model.
import mem_stage_pkg::*;

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  alu_op_t     aluop;
  logic        wreg_in;
  logic [4:0]  waddr_in;
  logic [31:0] alurslt;
  logic [31:0] sdata;
  logic        gnt;
  logic [7:0]  din;
  logic        req;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        stall;
  logic        wreg_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;

  logic [7:0] ram [0:4095] = '{default: 8'h00};
  logic [7:0] model [0:4095];
  int wr_count = 0;
  int checks = 0;
  int errors = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .aluop_EXMEM_i        (aluop),
    .wreg_EXMEM_i         (wreg_in),
    .waddr_EXMEM_i        (waddr_in),
    .alurslt_EXMEM_i      (alurslt),
    .SdataBoffset_EXMEM_i (sdata),
    .mem_gnt_i            (gnt),
    .mem_din_i            (din),
    .mem_req_o            (req),
    .mem_a_o              (mem_a),
    .mem_dout_o           (mem_dout),
    .mem_wr_o             (mem_wr),
    .stallreq_MEM_o       (stall),
    .wreg_MEMWB_o         (wreg_out),
    .waddr_MEMWB_o        (waddr_out),
    .wdata_MEMWB_o        (wdata_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    din <= ram[mem_a[11:0]];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(alu_op_t op);
    if (op inside {ALU_LB_OP, ALU_LBU_OP, ALU_SB_OP}) return 1;
    if (op inside {ALU_LH_OP, ALU_LHU_OP, ALU_SH_OP}) return 2;
    if (op inside {ALU_LW_OP, ALU_SW_OP}) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(alu_op_t op,
                                             logic [31:0] a);
    logic [31:0] v;
    logic [31:0] p;
    v = 0;
    for (int i = 0; i < size_of(op); i++) begin
      p = a + i;
      v = v | ({24'd0, model[p[11:0]]} << (8 * i));
    end
    if (op == ALU_LB_OP && v[7]) v = v | 32'hFFFFFF00;
    if (op == ALU_LH_OP && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic run_op(input alu_op_t op, input logic w,
                        input logic [4:0] wa,
                        input logic [31:0] a, input logic [31:0] d,
                        input int gd, input bit rg,
                        output logic [31:0] got, output int cyc);
    int n;
    int k;
    int wr0;
    bit ld;
    bit st;
    logic [31:0] exp;
    logic [31:0] p;
    n  = size_of(op);
    ld = (n > 0) && !(op inside {ALU_SB_OP, ALU_SH_OP, ALU_SW_OP});
    st = (n > 0) && !ld;
    exp = ld ? model_load(op, a) : (st ? 32'd0 : a);
    k = 0;
    @(negedge clk);
    aluop = op; wreg_in = w; waddr_in = wa;
    alurslt = a; sdata = d; gnt = (gd == 0);
    wr0 = wr_count;
    while (1) begin
      #1;
      if (!stall) break;
      if (k > 60) begin
        check("stall_timeout", 32'(k), 32'd0);
        break;
      end
      check("req_busy", {31'd0, req}, 32'd1);
      check("wreg_busy", {31'd0, wreg_out}, 32'd0);
      if (k > gd && k <= gd + n) begin
        check("addr", mem_a, a + 32'(k - gd - 1));
        check("wr_xfer", {31'd0, mem_wr}, {31'd0, st});
        if (st)
          check("dout", {24'd0, mem_dout}, {24'd0, d[8*(k-gd-1) +: 8]});
      end else begin
        check("wr_idle", {31'd0, mem_wr}, 32'd0);
      end
      k++;
      @(negedge clk);
      gnt = (k < gd) ? 1'b0 : ((k > gd && rg) ? 1'($urandom) : 1'b1);
    end
    cyc = k + 1;
    got = wdata_out;
    check("req_done", {31'd0, req}, 32'd0);
    check("wreg_done", {31'd0, wreg_out}, {31'd0, w});
    check("waddr_done", {27'd0, waddr_out}, {27'd0, wa});
    check("wdata_model", got, exp);
    check("cycles_model", 32'(cyc),
          32'(n == 0 ? 1 : gd + n + (ld ? 3 : 2)));
    check("wr_count", 32'(wr_count - wr0), 32'(st ? n : 0));
    if (st) begin
      for (int i = 0; i < n; i++) begin
        p = a + i;
        model[p[11:0]] = d[8*i +: 8];
      end
      for (int i = 0; i <= n; i++) begin
        p = a + i;
        check("ram", {24'd0, ram[p[11:0]]}, {24'd0, model[p[11:0]]});
      end
    end
  endtask

  typedef struct {
    alu_op_t     op;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] a;
    logic [31:0] d;
    int          gd;
    logic [31:0] exp_wdata;
    int          exp_cyc;
  } vec_t;

  vec_t tbl [15];
  alu_op_t ops [10];

  initial begin
    logic [31:0] got;
    int cyc;
    int wr0;
    logic [31:0] a;
    alu_op_t op;

    for (int i = 0; i < 4096; i++) model[i] = 8'h00;

    tbl[0]  = '{ALU_ADD_OP, 1'b1, 5'd5, 32'h1234, 32'h0, 0, 32'h1234, 1};
    tbl[1]  = '{ALU_SW_OP,  1'b0, 5'd0, 32'h100, 32'h12345678, 0, 32'h0, 6};
    tbl[2]  = '{ALU_SB_OP,  1'b0, 5'd0, 32'h200, 32'h80, 0, 32'h0, 3};
    tbl[3]  = '{ALU_SH_OP,  1'b0, 5'd0, 32'h202, 32'h8001, 0, 32'h0, 4};
    tbl[4]  = '{ALU_LW_OP,  1'b1, 5'd7, 32'h100, 32'h0, 0, 32'h12345678, 7};
    tbl[5]  = '{ALU_LB_OP,  1'b1, 5'd8, 32'h200, 32'h0, 0, 32'hFFFFFF80, 4};
    tbl[6]  = '{ALU_LBU_OP, 1'b1, 5'd8, 32'h200, 32'h0, 0, 32'h00000080, 4};
    tbl[7]  = '{ALU_LH_OP,  1'b1, 5'd9, 32'h202, 32'h0, 0, 32'hFFFF8001, 5};
    tbl[8]  = '{ALU_LHU_OP, 1'b1, 5'd9, 32'h202, 32'h0, 0, 32'h00008001, 5};
    tbl[9]  = '{ALU_SH_OP,  1'b0, 5'd0, 32'h300, 32'hAABBCCDD, 3, 32'h0, 7};
    tbl[10] = '{ALU_SB_OP,  1'b0, 5'd0, 32'h10, 32'h11, 0, 32'h0, 3};
    tbl[11] = '{ALU_SB_OP,  1'b0, 5'd0, 32'h10, 32'h22, 0, 32'h0, 3};
    tbl[12] = '{ALU_SW_OP,  1'b0, 5'd0, 32'hFFFFFFFE, 32'hCAFEBABE, 0, 32'h0, 6};
    tbl[13] = '{ALU_LW_OP,  1'b1, 5'd11, 32'hFFFFFFFE, 32'h0, 0, 32'hCAFEBABE, 7};
    tbl[14] = '{ALU_SUB_OP, 1'b0, 5'd3, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 1};

    ops = '{ALU_ADD_OP, ALU_SUB_OP, ALU_LB_OP, ALU_LH_OP, ALU_LW_OP,
            ALU_LBU_OP, ALU_LHU_OP, ALU_SB_OP, ALU_SH_OP, ALU_SW_OP};

    rst = 1'b1;
    aluop = ALU_ADD_OP; wreg_in = 1'b1; waddr_in = 5'd5;
    alurslt = 32'h55; sdata = 32'h0; gnt = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wreg", {31'd0, wreg_out}, 32'd0);
    check("rst_wdata", wdata_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].op, tbl[i].w, tbl[i].wa, tbl[i].a, tbl[i].d,
             tbl[i].gd, 1'b0, got, cyc);
      check($sformatf("tbl%0d_wdata", i), got, tbl[i].exp_wdata);
      check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
    end
    check("sh_byte0", {24'd0, ram[12'h300]}, 32'hDD);
    check("sh_byte1", {24'd0, ram[12'h301]}, 32'hCC);
    check("sh_untouched", {24'd0, ram[12'h302]}, 32'h00);
    check("sb_twice", {24'd0, ram[12'h010]}, 32'h22);

    // reset while a word store is mid-transfer
    @(negedge clk);
    aluop = ALU_SW_OP; wreg_in = 1'b0; waddr_in = 5'd0;
    alurslt = 32'h500; sdata = 32'h44332211; gnt = 1'b1;
    wr0 = wr_count;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, req}, 32'd0);
    check("arst_wr", {31'd0, mem_wr}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_addr", mem_a, 32'd0);
    check("arst_dout", {24'd0, mem_dout}, 32'd0);
    aluop = ALU_ADD_OP; wreg_in = 1'b1; waddr_in = 5'd12;
    alurslt = 32'h0BADF00D;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("arst_hold_wr", {31'd0, mem_wr}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_wreg", {31'd0, wreg_out}, 32'd1);
    check("post_rst_waddr", {27'd0, waddr_out}, 32'd12);
    check("post_rst_wdata", wdata_out, 32'h0BADF00D);
    check("arst_writes", 32'(wr_count - wr0), 32'd2);
    check("arst_b0", {24'd0, ram[12'h500]}, 32'h11);
    check("arst_b1", {24'd0, ram[12'h501]}, 32'h22);
    check("arst_b2", {24'd0, ram[12'h502]}, {24'd0, model[12'h502]});
    check("arst_b3", {24'd0, ram[12'h503]}, {24'd0, model[12'h503]});
    model[12'h500] = 8'h11;
    model[12'h501] = 8'h22;

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 9)];
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFD + $urandom_range(0, 2)
                                      : 32'h800 + $urandom_range(0, 32'h7F0);
      run_op(op, 1'($urandom), 5'($urandom), a, $urandom,
             $urandom_range(0, 3), 1'b1, got, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
